// File: rtl/opus_sched.sv
// opus_sched: two-requester transaction scheduler in front of the opus I/O FSM.
// After reset it drives a fixed init command sequence. It then arbitrates the
// two request lines round-robin and runs each transaction as CMD -> [MACK] ->
// XFER -> DONE, producing a command word for the I/O FSM on ptext.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   req[1:0]        per-requester request level, held until done
//   req_wr[1:0]     per-requester type (1 = write)
//   req_mack[1:0]   per-requester memory-ack variant
//   mack_done       external memory acknowledge that ends the MACK wait
//   rtext[5:0]      status word from the I/O FSM, must read 100000 in IDLE
//   ptext[4:0]      command word to the I/O FSM
//   grant[1:0]      one-hot owner of the current transaction
//   done[1:0]       one-cycle completion pulse for the owner
//   ready           high while IDLE
//   err             sticky error flag, cleared only by reset
//
// Every output is a register loaded with the value for the next state. As a
// result, ptext depends only on state and registered fields. The MACK release
// is therefore shown as one extra MACK cycle with rel set. That cycle drives
// ptext=10000, and the FSM moves to XFER after it.
module opus_sched #(
  parameter int MACK_TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic [1:0] req_wr,
  input  logic [1:0] req_mack,
  input  logic       mack_done,
  input  logic [5:0] rtext,
  output logic [4:0] ptext,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       ready,
  output logic       err
);

  localparam logic [7:0] CNT_LAST = 8'(MACK_TIMEOUT - 1);
  localparam logic [5:0] RT_OK    = 6'b100000;

  typedef enum logic [3:0] {
    INIT1, INIT2A, INIT2B, INIT3, IDLE, CMD, MACK, XFER, DONE
  } state_t;

  state_t     state, nxt;
  logic       ptr, ptr_d;          // requester favoured when both request
  logic       wr_q, wr_d;
  logic       mack_q, mack_d;
  logic [7:0] cnt, cnt_d;          // MACK wait counter
  logic       xcnt, xcnt_d;        // XFER cycle counter
  logic       rel, rel_d;          // MACK release cycle in progress
  logic [4:0] ptext_d;
  logic [1:0] grant_d, done_d;
  logic       ready_d, err_d;
  logic       sel;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= INIT1;
      ptext  <= 5'b00100;
      grant  <= 2'b00;
      done   <= 2'b00;
      ready  <= 1'b0;
      err    <= 1'b0;
      ptr    <= 1'b0;
      wr_q   <= 1'b0;
      mack_q <= 1'b0;
      cnt    <= 8'd0;
      xcnt   <= 1'b0;
      rel    <= 1'b0;
    end else begin
      state  <= nxt;
      ptext  <= ptext_d;
      grant  <= grant_d;
      done   <= done_d;
      ready  <= ready_d;
      err    <= err_d;
      ptr    <= ptr_d;
      wr_q   <= wr_d;
      mack_q <= mack_d;
      cnt    <= cnt_d;
      xcnt   <= xcnt_d;
      rel    <= rel_d;
    end
  end

  always_comb begin
    nxt     = state;
    grant_d = grant;
    err_d   = err;
    ptr_d   = ptr;
    wr_d    = wr_q;
    mack_d  = mack_q;
    cnt_d   = cnt;
    xcnt_d  = xcnt;
    rel_d   = rel;
    sel     = (req == 2'b11) ? ptr : req[1];

    case (state)
      INIT1:  nxt = INIT2A;
      INIT2A: nxt = INIT2B;
      INIT2B: nxt = INIT3;
      INIT3:  nxt = IDLE;
      IDLE: begin
        if (rtext != RT_OK) err_d = 1'b1;
        if (req != 2'b00) begin
          wr_d    = req_wr[sel];
          mack_d  = req_mack[sel];
          ptr_d   = ~sel;
          grant_d = sel ? 2'b10 : 2'b01;
          nxt     = CMD;
        end
      end
      CMD: begin
        cnt_d  = 8'd0;
        xcnt_d = 1'b0;
        rel_d  = 1'b0;
        nxt    = mack_q ? MACK : XFER;
      end
      MACK: begin
        if (rel) begin
          nxt = XFER;
        end else begin
          cnt_d = cnt + 8'd1;
          if (mack_done || cnt == CNT_LAST) begin
            rel_d = 1'b1;
            if (!mack_done) err_d = 1'b1;   // forced release on timeout
          end
        end
      end
      XFER: begin
        xcnt_d = xcnt + 1'b1;
        if (wr_q || xcnt) nxt = DONE;        // write 1 cycle, read 2
      end
      DONE: begin
        grant_d = 2'b00;
        nxt     = IDLE;
      end
      default: nxt = INIT1;
    endcase

    // Registered outputs take the value belonging to the state being entered.
    case (nxt)
      INIT1:          ptext_d = 5'b00100;
      INIT2A, INIT2B: ptext_d = 5'b01000;
      CMD:            ptext_d = {mack_d, 3'b001, wr_d};
      MACK:           ptext_d = {rel_d, 4'b0000};
      default:        ptext_d = 5'b00000;
    endcase
    done_d  = (nxt == DONE) ? grant_d : 2'b00;
    ready_d = (nxt == IDLE);
  end

endmodule

// File: tb/tb_opus_sched.sv
module tb_opus_sched;
  localparam int T = 6;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] req = 2'b00, req_wr = 2'b00, req_mack = 2'b00;
  logic       mack_done = 1'b0;
  logic [5:0] rtext = 6'b100000;
  logic [4:0] ptext;
  logic [1:0] grant, done;
  logic       ready, err;

  opus_sched #(.MACK_TIMEOUT(T)) dut (
    .CLK(CLK), .RST(RST), .req(req), .req_wr(req_wr), .req_mack(req_mack),
    .mack_done(mack_done), .rtext(rtext), .ptext(ptext), .grant(grant),
    .done(done), .ready(ready), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] gnt;
    string      seq;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   favour = 1'b0;   // model: requester preferred on contention
  logic err_m = 1'b0;    // model: sticky error

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_s(input string nm, input string act, input string exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %s expected %s", nm, act, exp);
    end
  endtask

  // Monitor: capture ptext from the first granted cycle to the done pulse.
  bit         cap = 1'b0;
  logic [1:0] cap_g;
  string      obs;
  always @(negedge CLK) begin
    exp_t e;
    if (grant == 2'b11 || done == 2'b11) begin
      miscompares++;
      $display("FAIL onehot: grant=%b done=%b", grant, done);
    end
    if (cap && grant == 2'b00) cap = 1'b0;   // transaction aborted by reset
    if (!cap && grant != 2'b00) begin
      cap = 1'b1; cap_g = grant; obs = "";
    end
    if (cap) obs = {obs, $sformatf("%02h", ptext)};
    if (done != 2'b00) begin
      if (!cap || sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_done: got %b expected none", done);
      end else begin
        e = sb.pop_front();
        chk("done_owner", {30'd0, done}, {30'd0, e.gnt});
        chk("grant_owner", {30'd0, cap_g}, {30'd0, e.gnt});
        chk_s("ptext_seq", obs, e.seq);
        chk("err_at_done", {31'd0, err}, {31'd0, e.err});
      end
      cap = 1'b0;
    end
  end

  // Called at a negedge where reset has just taken effect (state INIT1).
  task automatic check_init();
    string s;
    chk("rst_ptext", {27'd0, ptext}, 32'h04);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_done", {30'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    RST = 1'b0;
    s = "";
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      s = {s, $sformatf("%02h", ptext)};
      chk("init_ready", {31'd0, ready}, 32'd0);
    end
    chk_s("init_seq", s, "080800");
    @(negedge CLK);
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_ptext", {27'd0, ptext}, 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1; req = 2'b00; mack_done = 1'b0;
    @(negedge CLK);
    favour = 1'b0; err_m = 1'b0;
    check_init();
  endtask

  task automatic wait_ready();
    bit got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL wait_ready: got ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic issue(input logic [1:0] r, input logic [1:0] w,
                       input logic [1:0] mk, input int k);
    exp_t e;
    bit   ow, got;
    int   kk, m;
    wait_ready();
    req = r; req_wr = w; req_mack = mk;
    // reference model
    ow = (r == 2'b11) ? favour : r[1];
    favour = ~ow;
    e.gnt = ow ? 2'b10 : 2'b01;
    e.seq = $sformatf("%02h", {mk[ow], 3'b001, w[ow]});
    if (mk[ow]) begin
      kk = (k < 1) ? 1 : k;
      m  = (kk < T) ? kk : T;
      if (kk > T) err_m = 1'b1;
      for (int i = 0; i < m; i++) e.seq = {e.seq, "00"};
      e.seq = {e.seq, "10"};
    end
    e.seq = {e.seq, w[ow] ? "00" : "0000", "00"};
    e.err = err_m;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (grant != 2'b00) begin got = 1'b1; break; end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL wait_grant: got grant=00 expected %b", e.gnt);
    end
    // post-grant changes must be ignored
    req_wr = 2'($urandom); req_mack = 2'($urandom); req = 2'($urandom_range(1, 3));
    mack_done = (k == 0);
    got = 1'b0;
    for (int c = 1; c < 100; c++) begin
      @(negedge CLK);
      if (c == k) mack_done = 1'b1;
      if (done != 2'b00) begin got = 1'b1; break; end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL wait_done: got done=00 expected %b", e.gnt);
    end
    req = 2'b00; mack_done = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check_init();

    issue(2'b01, 2'b00, 2'b00, 0);    // single read, no mack
    issue(2'b10, 2'b10, 2'b10, 5);    // write with mack after 5 cycles
    for (int i = 0; i < 3; i++) issue(2'b11, 2'b11, 2'b00, 0);  // alternation
    issue(2'b01, 2'b00, 2'b01, 20);   // mack timeout -> err

    for (int i = 0; i < 25; i++)
      issue(2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom),
            int'($urandom_range(0, T + 2)));

    // reset in the middle of XFER: no done, init reruns, err cleared
    wait_ready();
    req = 2'b01; req_wr = 2'b00; req_mack = 2'b00;
    @(negedge CLK);
    chk("abort_grant", {30'd0, grant}, 32'd1);
    @(negedge CLK);
    RST = 1'b1; req = 2'b00;
    @(negedge CLK);
    favour = 1'b0; err_m = 1'b0;
    check_init();

    for (int i = 0; i < 15; i++)
      issue(2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom),
            int'($urandom_range(0, T)));

    // bad status in IDLE sets sticky err
    wait_ready();
    chk("err_before_rtext", {31'd0, err}, 32'd0);
    rtext = 6'b000000;
    @(negedge CLK);
    rtext = 6'b100000;
    @(negedge CLK);
    chk("rtext_err", {31'd0, err}, 32'd1);
    err_m = 1'b1;
    issue(2'b10, 2'b00, 2'b00, 0);
    @(negedge CLK);
    chk("err_sticky", {31'd0, err}, 32'd1);

    do_reset();
    repeat (3) @(negedge CLK);
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/opus_sched.md
OPUS_SCHED -- requirements
Module: opus_sched

Interface
REQ-001 Parameter: MACK_TIMEOUT, default 255, maximum MACK wait in cycles (1..255) before forced release.
REQ-002 CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 req  in  2  per-requester transaction request; level, held until done.
REQ-005 req_wr  in  2  per-requester type: 1 = write, 0 = read.
REQ-006 req_mack  in  2  per-requester flag: 1 = memory-ack variant (RMACK/WMACK path).
REQ-007 mack_done  in  1  external memory acknowledge that releases the MACK wait.
REQ-008 rtext  in  6  status word from the opus I/O FSM.
REQ-009 ptext  out  5  command word to the opus I/O FSM.
REQ-010 grant  out  2  one-hot owner of the current transaction; 00 when none.
REQ-011 done  out  2  one-cycle completion pulse for the granted requester.
REQ-012 ready  out  1  high only in IDLE.
REQ-013 err  out  1  sticky error flag.

Function
REQ-014 All outputs SHALL be registered; ptext SHALL be a function of the current state and the registered transaction fields only.
REQ-015 States: INIT1, INIT2A, INIT2B, INIT3, IDLE, CMD, MACK, XFER, DONE.
REQ-016 INIT1: ptext=00100, 1 cycle -> INIT2A.
REQ-017 INIT2A, INIT2B: ptext=01000, 1 cycle each -> INIT3.
REQ-018 INIT3: ptext=00000, 1 cycle -> IDLE.
REQ-019 IDLE: ptext=00000; ready=1; grant=00; if req==00, stay in IDLE.
REQ-020 IDLE arbitration: if exactly one req bit is set, grant that requester; if both are set, grant the requester not served last (round-robin pointer); after reset the pointer favours requester 0.
REQ-021 On grant: latch the granted requester's req_wr and req_mack into wr_q and mack_q, update the pointer, go to CMD; grant is set at CMD entry and held through DONE.
REQ-022 CMD: ptext={mack_q,0,0,1,wr_q}, 1 cycle; go to MACK if mack_q=1, else XFER.
REQ-023 MACK: ptext={mack_done,4'b0000}; stay while mack_done=0; when mack_done=1, go to XFER.
REQ-024 MACK timeout: an 8-bit counter clears on MACK entry and increments each MACK cycle.
REQ-025 When the counter reaches MACK_TIMEOUT-1 with mack_done=0: set err, drive ptext=10000 in that cycle, go to XFER.
REQ-026 XFER: ptext=00000; read lasts 2 cycles, write lasts 1 cycle; then go to DONE.
REQ-027 DONE: ptext=00000; done[owner]=1 for 1 cycle; clear grant; go to IDLE.
REQ-028 req changes after grant SHALL be ignored until IDLE; req still high in IDLE SHALL start a new transaction.
REQ-029 Status check: in IDLE, if rtext!=100000, set err.
REQ-030 err SHALL be cleared only by RST.
REQ-031 done and grant SHALL never be set for both requesters at once.

Reset
REQ-032 RST=1 at a clock edge: state=INIT1, ptext=00100, grant=00, done=00, ready=0, err=0, pointer favours requester 0, wr_q=0, mack_q=0, timeout counter=0.
REQ-033 RST mid-transaction SHALL abort without a done pulse and rerun the full init sequence.
REQ-034 RST has priority over every other input.

Verification
REQ-035 Release RST -> ptext 00100, 01000, 01000, 00000 on consecutive cycles; ready=1 at cycle 5.
REQ-036 req=01, req_wr=00, req_mack=00 in IDLE -> grant=01, CMD ptext=00010, 2 XFER cycles, done=01 pulse 4 cycles after grant decision.
REQ-037 req=11 held, both writes, no mack -> grants alternate 01,10,01,...; each CMD ptext=00011; done never on both bits.
REQ-038 req=10, req_wr=10, req_mack=10; mack_done=1 after 5 MACK cycles -> CMD ptext=10011, ptext=00000 for 5 cycles then 10000, XFER 1 cycle, done=10; err=0.
REQ-039 mack read with mack_done=0, MACK_TIMEOUT=4 -> err=1 after 4 MACK cycles, ptext=10000, then done pulse; err stays 1 until RST.
REQ-040 rtext=000000 in IDLE -> err=1; RST asserted during XFER -> no done pulse, init sequence restarts.
